// File: rtl/fifo_pkg.sv
// Shared types and sizes for the 16-bit FIFO and its write-side packer.
package fifo_pkg;

  localparam int unsigned FIFO_W     = 16;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned FIFO_DEPTH = 15;
  localparam int unsigned LEVEL_W    = 5;

  typedef enum logic {
    LO = 1'b0,
    HI = 1'b1
  } pack_state_e;

endpackage

// File: rtl/occ_counter.sv
// Up/down occupancy counter: saturates at MAX, never goes below zero.
module occ_counter #(
  parameter int unsigned W   = 5,
  parameter int unsigned MAX = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count
);

  logic up_c;
  logic down_c;

  assign up_c   = inc && (count < W'(MAX));
  assign down_c = dec && (count != '0);

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (up_c && !down_c) begin
      count <= count + W'(1);
    end else if (down_c && !up_c) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Packs a byte stream into 16-bit words (high byte first) for the FIFO,
// tracking occupancy itself since the FIFO has no full flag.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int unsigned       DEPTH = FIFO_DEPTH,
  parameter logic [BYTE_W-1:0] PAD   = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BYTE_W-1:0]  in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  input  logic               fifo_rd,
  output logic               wr,
  output logic [FIFO_W-1:0]  din,
  output logic [LEVEL_W-1:0] level,
  output logic [FIFO_W-1:0]  words_out
);

  pack_state_e       state;
  logic [BYTE_W-1:0] hi_q;
  logic              accept_c;
  logic              commit_c;
  logic [FIFO_W-1:0] word_c;

  assign in_ready = level < LEVEL_W'(DEPTH);
  assign accept_c = in_valid && in_ready;
  assign commit_c = accept_c && ((state == HI) || in_last);
  assign word_c   = (state == HI) ? {hi_q, in_data} : {in_data, PAD};

  // Byte-pairing FSM with registered write strobe and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LO;
      hi_q      <= '0;
      wr        <= 1'b0;
      din       <= '0;
      words_out <= '0;
    end else begin
      wr <= commit_c;
      if (commit_c) begin
        din       <= word_c;
        words_out <= words_out + FIFO_W'(1);
      end
      case (state)
        LO: begin
          if (accept_c && !in_last) begin
            hi_q  <= in_data;
            state <= HI;
          end
        end
        HI: begin
          if (accept_c) begin
            state <= LO;
          end
        end
        default: state <= LO;
      endcase
    end
  end

  // Space is reserved at commit, one cycle ahead of the FIFO seeing wr.
  occ_counter #(
    .W   (LEVEL_W),
    .MAX (DEPTH)
  ) u_level (
    .clk   (clk),
    .rst   (rst),
    .inc   (commit_c),
    .dec   (fifo_rd),
    .count (level)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed and random checks of fifo_word_packer against a byte-queue model.
module tb_fifo_word_packer;

  localparam int unsigned DEPTH = 15;
  localparam logic [7:0]  PAD   = 8'h00;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic        fifo_rd;
  logic        wr;
  logic [15:0] din;
  logic [4:0]  level;
  logic [15:0] words_out;

  fifo_word_packer #(
    .DEPTH (DEPTH),
    .PAD   (PAD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .fifo_rd   (fifo_rd),
    .wr        (wr),
    .din       (din),
    .level     (level),
    .words_out (words_out)
  );

  always #5 clk = ~clk;

  int passed;
  int total;
  int dut_wr_cnt;

  // Reference model: pending bytes of the current word, occupancy, outputs.
  logic [7:0]  pend[$];
  int          m_level;
  logic        m_wr;
  logic [15:0] m_din;
  logic [15:0] m_words;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    pend.delete();
    m_level = 0;
    m_wr    = 1'b0;
    m_din   = 16'h0000;
    m_words = 16'h0000;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".wr"},        32'(wr),        32'(m_wr));
    check({tag, ".din"},       32'(din),       32'(m_din));
    check({tag, ".level"},     32'(level),     32'(m_level));
    check({tag, ".words_out"}, 32'(words_out), 32'(m_words));
  endtask

  // One clock: drive inputs, predict, advance, compare.
  task automatic step(input logic v, input logic [7:0] d, input logic l, input logic r);
    logic        acc;
    logic        commit;
    logic        dec;
    logic [15:0] word;
    in_valid = v;
    in_data  = d;
    in_last  = l;
    fifo_rd  = r;
    check("in_ready", 32'(in_ready), 32'(m_level < int'(DEPTH)));
    acc    = v && (m_level < int'(DEPTH));
    commit = 1'b0;
    word   = 16'h0000;
    if (acc) begin
      pend.push_back(d);
      if (l || pend.size() == 2) begin
        word   = (pend.size() == 2) ? {pend[0], pend[1]} : {pend[0], PAD};
        commit = 1'b1;
        pend.delete();
      end
    end
    dec = r && (m_level > 0);
    @(posedge clk);
    #1;
    m_wr = commit;
    if (commit) begin
      m_din   = word;
      m_words = m_words + 16'd1;
    end
    m_level = m_level + int'(commit) - int'(dec);
    if (wr) dut_wr_cnt++;
    check_outputs("step");
    in_valid = 1'b0;
    fifo_rd  = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    fifo_rd  = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_outputs("reset");
    check("reset.in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int wr_base;
    clk        = 1'b0;
    passed     = 0;
    total      = 0;
    dut_wr_cnt = 0;
    in_data    = 8'h00;
    rst        = 1'b1;
    model_reset();
    @(posedge clk);
    do_reset();

    // Pair of bytes packs high-first.
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    check("t1.no_wr_on_first", 32'(wr), 32'd0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    check("t1.din", 32'(din), 32'h0000_A1B2);
    check("t1.level", 32'(level), 32'd1);
    check("t1.words", 32'(words_out), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Lone final byte is padded.
    step(1'b1, 8'h5C, 1'b1, 1'b0);
    check("t2.wr", 32'(wr), 32'd1);
    check("t2.din", 32'(din), 32'h0000_5C00);
    step(1'b1, 8'h77, 1'b1, 1'b0);
    check("t2.lo_after_last", 32'(din), 32'h0000_7700);

    // Drain, then fill to DEPTH.
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t3.drained", 32'(level), 32'd0);
    wr_base = dut_wr_cnt;
    for (int i = 0; i < 30; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    check("t3.writes", 32'(dut_wr_cnt - wr_base), 32'd15);
    check("t3.level_full", 32'(level), 32'd15);
    check("t3.not_ready", 32'(in_ready), 32'd0);
    wr_base = dut_wr_cnt;
    for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
    check("t3.no_wr_when_full", 32'(dut_wr_cnt - wr_base), 32'd0);

    // One read reopens the input.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t4.level", 32'(level), 32'd14);
    check("t4.ready", 32'(in_ready), 32'd1);
    step(1'b1, 8'h3C, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    check("t4.din", 32'(din), 32'h0000_3CC3);
    check("t4.refull", 32'(level), 32'd15);

    // Commit coincident with a read; read at empty.
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t5.level7", 32'(level), 32'd7);
    step(1'b1, 8'h12, 1'b0, 1'b0);
    step(1'b1, 8'h34, 1'b0, 1'b1);
    check("t5.commit_and_rd", 32'(level), 32'd7);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    check("t5.rd_at_empty", 32'(level), 32'd0);

    // Reset mid-word discards the held byte.
    step(1'b1, 8'h11, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 8'h22, 1'b0, 1'b0);
    check("t6.no_partial", 32'(wr), 32'd0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    check("t6.din", 32'(din), 32'h0000_2233);
    check("t6.words", 32'(words_out), 32'd1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
